// File: rtl/hexseg_pkg.sv
// hexseg_pkg
// Shared constants for the hex 7-segment scanner.
//   SEG_OFF        : all segments dark (active-low pins)
//   HEX_SEG_TABLE  : active-high {g,f,e,d,c,b,a} pattern for hex digits 0..F
//   hex2seg()      : nibble -> active-high segment pattern
package hexseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/hexseg_lzmask.sv
// hexseg_lzmask
// Combinational leading-zero detector for a packed hex word.
// Ports:
//   value   in  4*NUM_DIGITS  packed hex word, digit 0 rightmost
//   lz_mask out NUM_DIGITS    1 = digit is a leading zero (it and every
//                             higher digit are 0); digit 0 is never flagged
module hexseg_lzmask #(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   lz_mask
);

  logic zero_run;

  // Walk from the most significant digit downwards; the run of zeros stays
  // true only while every digit seen so far is zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (value[4*i +: 4] == 4'h0);
      if (i != 0) lz_mask[i] = zero_run;
    end
  end

endmodule

// File: rtl/hexseg_scan.sv
// hexseg_scan
// Time-multiplexed driver for an N-digit common-anode hex 7-segment display.
// Each digit gets a slot of SCAN_DIV cycles; the first DEAD cycles of a slot
// keep every anode off to avoid ghosting. New data is captured into a pending
// register on load and only becomes visible at the frame boundary.
// Optional feature macro: HEXSEG_PWM_EN (adds brightness[3:0] duty control).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   value        packed hex word (digit i = value[4i+3:4i])
//   load         capture value/blank_mask/dp_mask into pending
//   blank_mask   1 = force digit dark
//   dp_mask      1 = light decimal point of that digit
//   lz_suppress  live enable for leading-zero suppression
//   brightness   (HEXSEG_PWM_EN only) lit cycles per 16-cycle window
//   seg, dp, an  registered active-low display pins
//   frame_tick   one-cycle pulse at the start of each frame
module hexseg_scan
  import hexseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_suppress,
`ifdef HEXSEG_PWM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   pend_value_q, pend_value_d;
  logic [NUM_DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0]   act_value_q, act_value_d;
  logic [NUM_DIGITS-1:0]     act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic                      frame_tick_q, frame_tick_d;

  logic [NUM_DIGITS-1:0]     lz_mask;
  logic                      slot_wrap;
  logic                      frame_end;
  logic                      pwm_on;
  logic                      digit_dark;

  hexseg_lzmask #(.NUM_DIGITS(NUM_DIGITS)) u_lzmask (
    .value   (act_value_q),
    .lz_mask (lz_mask)
  );

  // Scan position, pending capture and frame-synchronous promotion of the
  // pending data. A load in the boundary cycle is the one promoted.
  always_comb begin
    slot_wrap    = (cnt_q == CNT_LAST);
    frame_end    = slot_wrap && (idx_q == IDX_LAST);
    cnt_d        = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    pend_value_d = pend_value_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    if (load) begin
      pend_value_d = value;
      pend_blank_d = blank_mask;
      pend_dp_d    = dp_mask;
    end

    act_value_d  = act_value_q;
    act_blank_d  = act_blank_q;
    act_dp_d     = act_dp_q;
    if (frame_end) begin
      act_value_d = pend_value_d;
      act_blank_d = pend_blank_d;
      act_dp_d    = pend_dp_d;
    end
    frame_tick_d = frame_end;
  end

  // Pin values for the current scan position; they reach the pins one cycle
  // later through the output registers.
  always_comb begin
`ifdef HEXSEG_PWM_EN
    // Offset into the lit part of the slot never goes negative here because
    // it is only used once the dead time is over.
    pwm_on = (4'(cnt_q - CNT_DEAD) < brightness);
`else
    pwm_on = 1'b1;
`endif
    digit_dark = act_blank_q[idx_q] | (lz_suppress & lz_mask[idx_q]);
    seg_d      = SEG_OFF;
    dp_d       = 1'b1;
    an_d       = '1;
    if ((cnt_q >= CNT_DEAD) && pwm_on) begin
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (IW'(i) != idx_q);
      seg_d = digit_dark ? SEG_OFF : ~hex2seg(act_value_q[idx_q*4 +: 4]);
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_value_q <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      act_value_q  <= '0;
      act_blank_q  <= '0;
      act_dp_q     <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_value_q <= pend_value_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      act_value_q  <= act_value_d;
      act_blank_q  <= act_blank_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hexseg_scan.sv
// tb_hexseg_scan
// Scoreboard bench for hexseg_scan (NUM_DIGITS=4, SCAN_DIV=8, DEAD=2).
// A reference model works from the absolute cycle count since reset and
// pushes the expected pin state for every clock edge into a queue; a monitor
// pops and compares on the falling edge.
module tb_hexseg_scan;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int DD = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       ft;
  } outVec_t;

  localparam outVec_t DARK = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, ft: 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [15:0] value = '0;
  logic       load = 1'b0;
  logic [3:0] blank_mask = '0;
  logic [3:0] dp_mask = '0;
  logic       lz_suppress = 1'b0;
`ifdef HEXSEG_PWM_EN
  logic [3:0] brightness = 4'd3;
`endif
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  outVec_t expQ[$];

  // Segment patterns for 0..F, lit segments as ones
  logic [6:0] segTable [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  hexseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .DEAD(DD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .load        (load),
    .blank_mask  (blank_mask),
    .dp_mask     (dp_mask),
    .lz_suppress (lz_suppress),
`ifdef HEXSEG_PWM_EN
    .brightness  (brightness),
`endif
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Compare the pins against one expected vector
  task automatic checkOutput(input string name, input outVec_t expv);
    outVec_t actv;
    actv = '{seg: seg, dp: dp, an: an, ft: frame_tick};
    checks++;
    if (actv !== expv) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got seg=%h dp=%b an=%h ft=%b want seg=%h dp=%b an=%h ft=%b",
               name, $time, actv.seg, actv.dp, actv.an, actv.ft,
               expv.seg, expv.dp, expv.an, expv.ft);
    end
  endtask

  // Drive one cycle of inputs (load pulses for that cycle only), then idle
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] b,
                               input logic [3:0] d, input logic ld,
                               input logic lz, input int idle);
    @(negedge clk); #1;
    value       = v;
    blank_mask  = b;
    dp_mask     = d;
    load        = ld;
    lz_suppress = lz;
    @(negedge clk); #1;
    load = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  // Reference model: time since reset gives slot, digit and phase directly
  int unsigned t;
  int          phase, digit;
  logic        boundary, lit, blanked;
  logic [15:0] pendVal, actVal;
  logic [3:0]  pendBlank, actBlank, pendDp, actDp, nib;
  outVec_t     e;

  initial begin
    t = 0;
    pendVal = '0; actVal = '0;
    pendBlank = '0; actBlank = '0; pendDp = '0; actDp = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0;
        pendVal = '0; actVal = '0;
        pendBlank = '0; actBlank = '0; pendDp = '0; actDp = '0;
        e = DARK;
      end else begin
        phase    = int'(t % SD);
        digit    = int'((t / SD) % N);
        boundary = (phase == SD - 1) && (digit == N - 1);
        e        = DARK;
        e.ft     = boundary;
        lit      = (phase >= DD);
`ifdef HEXSEG_PWM_EN
        lit      = lit && (((phase - DD) % 16) < int'(brightness));
`endif
        if (lit) begin
          e.an    = ~(4'b0001 << digit);
          nib     = 4'((actVal >> (4 * digit)) & 16'hF);
          blanked = actBlank[digit] ||
                    (lz_suppress && digit != 0 && (actVal >> (4 * digit)) == 16'h0);
          e.seg   = blanked ? 7'h7F : ~segTable[nib];
          e.dp    = ~actDp[digit];
        end
        if (load) begin
          pendVal = value; pendBlank = blank_mask; pendDp = dp_mask;
        end
        if (boundary) begin
          actVal = pendVal; actBlank = pendBlank; actDp = pendDp;
        end
        t++;
      end
      expQ.push_back(e);
    end
  end

  // Monitor: one expected vector per clock edge
  initial begin
    outVec_t expv;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        expv = expQ.pop_front();
        checkOutput("pins", expv);
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Free run with no data: every digit shows 0
    applyStimulus(16'h0000, 4'h0, 4'h0, 1'b0, 1'b0, 40);
    // New word lands mid-frame and appears only after the boundary
    applyStimulus(16'h12AF, 4'h0, 4'h0, 1'b1, 1'b0, 70);
    // Leading-zero suppression
    applyStimulus(16'h0070, 4'h0, 4'h0, 1'b1, 1'b1, 70);
    applyStimulus(16'h0000, 4'h0, 4'h0, 1'b1, 1'b1, 70);
    // Blanking and decimal points
    applyStimulus(16'h1234, 4'b0010, 4'b0100, 1'b1, 1'b0, 70);

    // Reset realignment, then an async reset pulse in the middle of digit 2
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    applyStimulus(16'h1234, 4'b0010, 4'b0100, 1'b1, 1'b0, 70);
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1 checkOutput("async_reset", DARK);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Randomized loads, masks and suppression
    for (int k = 0; k < 40; k++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 12)));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog t=%0t got no end want finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
